// File: rtl/lsqueue_disamb_pkg.sv
// Shared definitions for the load/store issue queue.
//   ISSUELS_FUNC_SW / ISSUELS_FUNC_LW : opcode encodings (store / load)
//   slot_op_e                         : per-slot next-state source select
package lsqueue_disamb_pkg;

  localparam logic ISSUELS_FUNC_SW = 1'b1;
  localparam logic ISSUELS_FUNC_LW = 1'b0;

  // Where a slot takes its next contents from.
  typedef enum logic [1:0] {
    SlotHold,   // keep own contents
    SlotShift,  // take the younger neighbour (collapse after a pop)
    SlotLoad    // take the instruction being dispatched
  } slot_op_e;

endpackage

// File: rtl/lsq_slot.sv
// One load/store queue entry.
//   clk, reset          : clock, synchronous active-high reset (clears the entry)
//   op                  : next-state source (hold / shift from neighbour / load dispatch)
//   sh_*                : contents of the younger neighbour slot
//   d_*                 : instruction being dispatched
//   cdb_*               : result broadcast, snooped for pending rs/rt
//   valid .. addr       : registered entry contents
// The effective address is formed here, once, when rs becomes known, so the
// issue path only ever reads a register.
module lsq_slot
  import lsqueue_disamb_pkg::*;
#(
  parameter int unsigned TAG_W  = 6,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned OFF_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  slot_op_e          op,
  input  logic              sh_valid,
  input  logic              sh_opcode,
  input  logic [OFF_W-1:0]  sh_offset,
  input  logic [TAG_W-1:0]  sh_rs_tag,
  input  logic              sh_rs_valid,
  input  logic [TAG_W-1:0]  sh_rt_tag,
  input  logic [DATA_W-1:0] sh_rt_data,
  input  logic              sh_rt_valid,
  input  logic [DATA_W-1:0] sh_addr,
  input  logic              d_opcode,
  input  logic [OFF_W-1:0]  d_offset,
  input  logic [TAG_W-1:0]  d_rs_tag,
  input  logic [DATA_W-1:0] d_rs_data,
  input  logic              d_rs_valid,
  input  logic [TAG_W-1:0]  d_rt_tag,
  input  logic [DATA_W-1:0] d_rt_data,
  input  logic              d_rt_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  input  logic              cdb_valid,
  output logic              valid,
  output logic              opcode,
  output logic [OFF_W-1:0]  offset,
  output logic [TAG_W-1:0]  rs_tag,
  output logic              rs_valid,
  output logic [TAG_W-1:0]  rt_tag,
  output logic [DATA_W-1:0] rt_data,
  output logic              rt_valid,
  output logic [DATA_W-1:0] addr
);

  logic              valid_q, opcode_q, rs_valid_q, rt_valid_q;
  logic [OFF_W-1:0]  offset_q;
  logic [TAG_W-1:0]  rs_tag_q, rt_tag_q;
  logic [DATA_W-1:0] rt_data_q, addr_q;

  logic              src_valid, src_opcode, src_rs_valid, src_rt_valid;
  logic [OFF_W-1:0]  src_offset;
  logic [TAG_W-1:0]  src_rs_tag, src_rt_tag;
  logic [DATA_W-1:0] src_rt_data, src_addr;

  logic              rs_hit, rt_hit, load_rs;
  logic [DATA_W-1:0] base, sum;

  // Source mux: the snoop below applies to whichever contents land here.
  always_comb begin
    src_valid    = valid_q;
    src_opcode   = opcode_q;
    src_offset   = offset_q;
    src_rs_tag   = rs_tag_q;
    src_rs_valid = rs_valid_q;
    src_rt_tag   = rt_tag_q;
    src_rt_data  = rt_data_q;
    src_rt_valid = rt_valid_q;
    src_addr     = addr_q;
    case (op)
      SlotShift: begin
        src_valid    = sh_valid;
        src_opcode   = sh_opcode;
        src_offset   = sh_offset;
        src_rs_tag   = sh_rs_tag;
        src_rs_valid = sh_rs_valid;
        src_rt_tag   = sh_rt_tag;
        src_rt_data  = sh_rt_data;
        src_rt_valid = sh_rt_valid;
        src_addr     = sh_addr;
      end
      SlotLoad: begin
        src_valid    = 1'b1;
        src_opcode   = d_opcode;
        src_offset   = d_offset;
        src_rs_tag   = d_rs_tag;
        src_rs_valid = d_rs_valid;
        src_rt_tag   = d_rt_tag;
        src_rt_data  = d_rt_data;
        src_rt_valid = d_rt_valid;
        src_addr     = '0;
      end
      default: ;
    endcase
  end

  // Invalid slots never snoop, so empty slots stay all-zero.
  assign rs_hit  = src_valid & ~src_rs_valid & cdb_valid & (cdb_tag == src_rs_tag);
  assign rt_hit  = src_valid & ~src_rt_valid & cdb_valid & (cdb_tag == src_rt_tag);
  assign load_rs = (op == SlotLoad) & d_rs_valid;

  // Single adder: base is the dispatched rs value or the broadcast value.
  assign base = load_rs ? d_rs_data : cdb_data;
  assign sum  = base + DATA_W'($signed(src_offset));

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q    <= 1'b0;
      opcode_q   <= 1'b0;
      offset_q   <= '0;
      rs_tag_q   <= '0;
      rs_valid_q <= 1'b0;
      rt_tag_q   <= '0;
      rt_data_q  <= '0;
      rt_valid_q <= 1'b0;
      addr_q     <= '0;
    end else begin
      valid_q    <= src_valid;
      opcode_q   <= src_opcode;
      offset_q   <= src_offset;
      rs_tag_q   <= src_rs_tag;
      rs_valid_q <= src_rs_valid | rs_hit;
      rt_tag_q   <= src_rt_tag;
      rt_data_q  <= rt_hit ? cdb_data : src_rt_data;
      rt_valid_q <= src_rt_valid | rt_hit;
      addr_q     <= (load_rs | rs_hit) ? sum : src_addr;
    end
  end

  assign valid    = valid_q;
  assign opcode   = opcode_q;
  assign offset   = offset_q;
  assign rs_tag   = rs_tag_q;
  assign rs_valid = rs_valid_q;
  assign rt_tag   = rt_tag_q;
  assign rt_data  = rt_data_q;
  assign rt_valid = rt_valid_q;
  assign addr     = addr_q;

endmodule

// File: rtl/lsqueue_disamb.sv
// Load/store issue queue with optional address disambiguation.
//   clk, reset        : clock, synchronous active-high reset
//   dispatch_*        : incoming instruction; dispatch_ready is combinational from issuels_done
//   cdb_*             : result broadcast snooped by every entry
//   issuels_*         : selected entry (entry 0 when nothing is eligible) and handshake
//   count             : number of valid entries
// Entries are age ordered (index 0 oldest). A pop collapses younger entries
// down by one; a push lands in the lowest free index after that collapse.
module lsqueue_disamb
  import lsqueue_disamb_pkg::*;
#(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned TAG_W     = 6,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned OFF_W     = 16,
  parameter int unsigned BYPASS_EN = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         dispatch_opcode,
  input  logic [OFF_W-1:0]             dispatch_offset,
  input  logic [TAG_W-1:0]             dispatch_rstag,
  input  logic [TAG_W-1:0]             dispatch_rttag,
  input  logic [DATA_W-1:0]            dispatch_rsdata,
  input  logic [DATA_W-1:0]            dispatch_rtdata,
  input  logic                         dispatch_rsvalid,
  input  logic                         dispatch_rtvalid,
  input  logic                         dispatch_en,
  output logic                         dispatch_ready,
  input  logic [TAG_W-1:0]             cdb_tag,
  input  logic [DATA_W-1:0]            cdb_data,
  input  logic                         cdb_valid,
  output logic                         issuels_opcode,
  output logic [TAG_W-1:0]             issuels_rttag,
  output logic [DATA_W-1:0]            issuels_addr,
  output logic [DATA_W-1:0]            issuels_data,
  output logic                         issuels_ready,
  input  logic                         issuels_done,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam int unsigned IdxW = $clog2(DEPTH);

  // Index DEPTH is a constant empty entry feeding the top slot's shift input.
  logic [DEPTH:0]             e_valid, e_opcode, e_rs_valid, e_rt_valid;
  logic [DEPTH:0][OFF_W-1:0]  e_offset;
  logic [DEPTH:0][TAG_W-1:0]  e_rs_tag, e_rt_tag;
  logic [DEPTH:0][DATA_W-1:0] e_rt_data, e_addr;

  assign e_valid[DEPTH]    = 1'b0;
  assign e_opcode[DEPTH]   = 1'b0;
  assign e_rs_valid[DEPTH] = 1'b0;
  assign e_rt_valid[DEPTH] = 1'b0;
  assign e_offset[DEPTH]   = '0;
  assign e_rs_tag[DEPTH]   = '0;
  assign e_rt_tag[DEPTH]   = '0;
  assign e_rt_data[DEPTH]  = '0;
  assign e_addr[DEPTH]     = '0;

  slot_op_e          slot_op [DEPTH];
  logic [DEPTH-1:0]  ready, blocked, eligible;
  logic [IdxW-1:0]   sel_idx;
  logic [CntW-1:0]   count_q, count_d, free_idx;
  logic              pop, push;

  for (genvar g = 0; g < DEPTH; g++) begin : g_slot
    lsq_slot #(
      .TAG_W (TAG_W),
      .DATA_W(DATA_W),
      .OFF_W (OFF_W)
    ) u_slot (
      .clk        (clk),
      .reset      (reset),
      .op         (slot_op[g]),
      .sh_valid   (e_valid[g+1]),
      .sh_opcode  (e_opcode[g+1]),
      .sh_offset  (e_offset[g+1]),
      .sh_rs_tag  (e_rs_tag[g+1]),
      .sh_rs_valid(e_rs_valid[g+1]),
      .sh_rt_tag  (e_rt_tag[g+1]),
      .sh_rt_data (e_rt_data[g+1]),
      .sh_rt_valid(e_rt_valid[g+1]),
      .sh_addr    (e_addr[g+1]),
      .d_opcode   (dispatch_opcode),
      .d_offset   (dispatch_offset),
      .d_rs_tag   (dispatch_rstag),
      .d_rs_data  (dispatch_rsdata),
      .d_rs_valid (dispatch_rsvalid),
      .d_rt_tag   (dispatch_rttag),
      .d_rt_data  (dispatch_rtdata),
      .d_rt_valid (dispatch_rtvalid),
      .cdb_tag    (cdb_tag),
      .cdb_data   (cdb_data),
      .cdb_valid  (cdb_valid),
      .valid      (e_valid[g]),
      .opcode     (e_opcode[g]),
      .offset     (e_offset[g]),
      .rs_tag     (e_rs_tag[g]),
      .rs_valid   (e_rs_valid[g]),
      .rt_tag     (e_rt_tag[g]),
      .rt_data    (e_rt_data[g]),
      .rt_valid   (e_rt_valid[g]),
      .addr       (e_addr[g])
    );
  end

  always_comb begin
    ready = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ready[i] = e_valid[i] & e_rs_valid[i] &
                 ((e_opcode[i] == ISSUELS_FUNC_SW) ? e_rt_valid[i] : 1'b1);
    end
  end

  // Age matrix: entry i is blocked by any older valid entry j that could alias it.
  // An entry under test is ready, so its own address is always known.
  always_comb begin
    blocked = '0;
    for (int i = 0; i < DEPTH; i++) begin
      for (int j = 0; j < DEPTH; j++) begin
        if (j < i && e_valid[j]) begin
          if (e_opcode[j] == ISSUELS_FUNC_SW && e_opcode[i] == ISSUELS_FUNC_SW) begin
            blocked[i] = 1'b1;
          end else if (!(e_opcode[j] == ISSUELS_FUNC_LW && e_opcode[i] == ISSUELS_FUNC_LW)) begin
            if (!e_rs_valid[j] || e_addr[j][DATA_W-1:2] == e_addr[i][DATA_W-1:2]) begin
              blocked[i] = 1'b1;
            end
          end
        end
      end
    end
  end

  always_comb begin
    if (BYPASS_EN != 0) begin
      eligible = ready & ~blocked;
    end else begin
      eligible    = '0;
      eligible[0] = ready[0];
    end
  end

  always_comb begin
    sel_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (eligible[i]) sel_idx = IdxW'(i);
    end
  end

  assign issuels_ready  = |eligible;
  assign issuels_opcode = e_opcode[sel_idx];
  assign issuels_rttag  = e_rt_tag[sel_idx];
  assign issuels_addr   = e_addr[sel_idx];
  assign issuels_data   = e_rt_data[sel_idx];

  assign pop            = issuels_ready & issuels_done;
  assign dispatch_ready = (count_q < CntW'(DEPTH)) | pop;
  assign push           = dispatch_en & dispatch_ready;
  assign free_idx       = pop ? (count_q - CntW'(1)) : count_q;
  assign count_d        = count_q + CntW'(push) - CntW'(pop);

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      slot_op[i] = SlotHold;
      if (push && free_idx == CntW'(i)) begin
        slot_op[i] = SlotLoad;
      end else if (pop && IdxW'(i) >= sel_idx) begin
        slot_op[i] = SlotShift;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: tb/tb_lsqueue_disamb.sv
module tb_lsqueue_disamb;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mode = 1'b1;  // 1 selects the bypass instance, 0 the FIFO instance
  logic        d_op = 1'b0, d_rsv = 1'b0, d_rtv = 1'b0, d_en = 1'b0;
  logic [15:0] d_off = '0;
  logic [5:0]  d_rstag = '0, d_rttag = '0, c_tag = '0;
  logic [31:0] d_rsdata = '0, d_rtdata = '0, c_data = '0;
  logic        c_valid = 1'b0, done = 1'b0;

  logic        f_dr, f_op, f_rdy, b_dr, b_op, b_rdy;
  logic [5:0]  f_tag, b_tag;
  logic [31:0] f_addr, f_data, b_addr, b_data;
  logic [2:0]  f_cnt, b_cnt;

  logic        a_dr, a_op, a_rdy;
  logic [5:0]  a_tag;
  logic [31:0] a_addr, a_data;
  logic [2:0]  a_cnt;

  typedef struct {
    logic        op;
    logic [5:0]  tag;
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t expq[$];
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  lsqueue_disamb #(.DEPTH(4), .TAG_W(6), .DATA_W(32), .OFF_W(16), .BYPASS_EN(0)) dut_f (
    .clk(clk), .reset(reset), .dispatch_opcode(d_op), .dispatch_offset(d_off),
    .dispatch_rstag(d_rstag), .dispatch_rttag(d_rttag), .dispatch_rsdata(d_rsdata),
    .dispatch_rtdata(d_rtdata), .dispatch_rsvalid(d_rsv), .dispatch_rtvalid(d_rtv),
    .dispatch_en(d_en & ~mode), .dispatch_ready(f_dr), .cdb_tag(c_tag), .cdb_data(c_data),
    .cdb_valid(c_valid), .issuels_opcode(f_op), .issuels_rttag(f_tag), .issuels_addr(f_addr),
    .issuels_data(f_data), .issuels_ready(f_rdy), .issuels_done(done), .count(f_cnt)
  );

  lsqueue_disamb #(.DEPTH(4), .TAG_W(6), .DATA_W(32), .OFF_W(16), .BYPASS_EN(1)) dut_b (
    .clk(clk), .reset(reset), .dispatch_opcode(d_op), .dispatch_offset(d_off),
    .dispatch_rstag(d_rstag), .dispatch_rttag(d_rttag), .dispatch_rsdata(d_rsdata),
    .dispatch_rtdata(d_rtdata), .dispatch_rsvalid(d_rsv), .dispatch_rtvalid(d_rtv),
    .dispatch_en(d_en & mode), .dispatch_ready(b_dr), .cdb_tag(c_tag), .cdb_data(c_data),
    .cdb_valid(c_valid), .issuels_opcode(b_op), .issuels_rttag(b_tag), .issuels_addr(b_addr),
    .issuels_data(b_data), .issuels_ready(b_rdy), .issuels_done(done), .count(b_cnt)
  );

  assign a_dr   = mode ? b_dr   : f_dr;
  assign a_op   = mode ? b_op   : f_op;
  assign a_rdy  = mode ? b_rdy  : f_rdy;
  assign a_tag  = mode ? b_tag  : f_tag;
  assign a_addr = mode ? b_addr : f_addr;
  assign a_data = mode ? b_data : f_data;
  assign a_cnt  = mode ? b_cnt  : f_cnt;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every accepted issue is checked against the head of the scoreboard.
  always @(negedge clk) begin
    if (!reset && a_rdy && done) begin
      if (expq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL issue_unexpected: got op=%0d addr=%0h with empty scoreboard", a_op, a_addr);
      end else begin
        exp_t e;
        e = expq.pop_front();
        chk("issue", {a_op, a_tag, a_addr, a_data}, {e.op, e.tag, e.addr, e.data});
      end
    end
  end

  task automatic expect_issue(input logic op, input logic [5:0] tag, input logic [31:0] addr,
                              input logic [31:0] data);
    exp_t e;
    e.op = op; e.tag = tag; e.addr = addr; e.data = data;
    expq.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    done = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic disp(input logic op, input logic [15:0] off, input logic [5:0] rstag,
                      input logic [31:0] rsdata, input logic rsv, input logic [5:0] rttag,
                      input logic [31:0] rtdata, input logic rtv);
    d_op = op; d_off = off; d_rstag = rstag; d_rsdata = rsdata; d_rsv = rsv;
    d_rttag = rttag; d_rtdata = rtdata; d_rtv = rtv; d_en = 1'b1;
    tick();
    d_en = 1'b0;
  endtask

  task automatic cdb(input logic [5:0] tag, input logic [31:0] data);
    c_tag = tag; c_data = data; c_valid = 1'b1;
    tick();
    c_valid = 1'b0;
  endtask

  task automatic wait_count(input string name, input int target, input int budget);
    int n = 0;
    while (int'(a_cnt) != target && n < budget) begin
      tick();
      n++;
    end
    chk(name, a_cnt, target);
  endtask

  initial begin
    tick();
    tick();
    reset = 1'b0;
    // Reset state
    chk("rst_count", b_cnt, 0);
    chk("rst_ready", b_rdy, 0);
    chk("rst_dready", b_dr, 1);
    chk("rst_outs", {b_op, b_tag, b_addr, b_data}, 0);
    chk("rst_f_outs", {f_cnt, f_rdy, f_dr, f_op, f_addr}, {3'd0, 1'b0, 1'b1, 1'b0, 32'd0});

    // Reset mid-operation, with a dispatch in the reset cycle
    mode = 1'b1;
    d_op = 1'b0; d_en = 1'b1; d_rsv = 1'b1; d_rsdata = 32'h10; #1;
    chk("no_disp_bypass", b_rdy, 0);
    d_en = 1'b0;
    disp(1'b0, 16'h0, 6'd0, 32'h10, 1'b1, 6'd1, 32'h0, 1'b1);
    chk("one_count", b_cnt, 1);
    chk("one_ready", b_rdy, 1);
    disp(1'b0, 16'h4, 6'd0, 32'h10, 1'b1, 6'd2, 32'h0, 1'b1);
    disp(1'b0, 16'h8, 6'd0, 32'h10, 1'b1, 6'd3, 32'h0, 1'b1);
    chk("three_count", b_cnt, 3);
    d_en = 1'b1; reset = 1'b1;
    tick();
    d_en = 1'b0; reset = 1'b0;
    chk("midrst", {b_cnt, b_rdy, b_dr}, {3'd0, 1'b0, 1'b1});

    // FIFO mode: unready store at head blocks a ready load behind it
    mode = 1'b0;
    do_reset();
    disp(1'b1, 16'h10, 6'd5, 32'h0, 1'b0, 6'd7, 32'hAAAA, 1'b1);
    disp(1'b0, 16'h4, 6'd0, 32'h300, 1'b1, 6'd9, 32'h0, 1'b1);
    chk("fifo_count", f_cnt, 2);
    chk("fifo_blocked", f_rdy, 0);
    expect_issue(1'b1, 6'd7, 32'h110, 32'hAAAA);
    expect_issue(1'b0, 6'd9, 32'h304, 32'h0);
    cdb(6'd5, 32'h100);
    chk("fifo_cdb_ready", {f_rdy, f_addr}, {1'b1, 32'h110});
    done = 1'b1;
    wait_count("fifo_drain", 0, 20);
    done = 1'b0;

    // Bypass allowed: different words; negative offset on the load
    mode = 1'b1;
    do_reset();
    disp(1'b1, 16'h0, 6'd0, 32'h200, 1'b1, 6'd11, 32'h0, 1'b0);
    disp(1'b0, 16'hFFF0, 6'd0, 32'h214, 1'b1, 6'd12, 32'h0, 1'b1);
    chk("byp_sel", {b_rdy, b_op, b_addr}, {1'b1, 1'b0, 32'h204});
    expect_issue(1'b0, 6'd12, 32'h204, 32'h0);
    done = 1'b1;
    tick();
    done = 1'b0;
    chk("byp_collapse", {b_cnt, b_rdy, b_op, b_tag, b_addr}, {3'd1, 1'b0, 1'b1, 6'd11, 32'h200});
    expect_issue(1'b1, 6'd11, 32'h200, 32'hDEAD);
    cdb(6'd11, 32'hDEAD);
    done = 1'b1;
    wait_count("byp_drain", 0, 20);
    done = 1'b0;

    // Bypass blocked: same word (0x200 vs 0x202); done while not ready is ignored
    do_reset();
    disp(1'b1, 16'h0, 6'd0, 32'h200, 1'b1, 6'd13, 32'h0, 1'b0);
    disp(1'b0, 16'h0, 6'd0, 32'h202, 1'b1, 6'd14, 32'h0, 1'b1);
    done = 1'b1;
    tick(); tick(); tick();
    chk("blk_hold", {b_cnt, b_rdy}, {3'd2, 1'b0});
    expect_issue(1'b1, 6'd13, 32'h200, 32'h55);
    expect_issue(1'b0, 6'd14, 32'h202, 32'h0);
    cdb(6'd13, 32'h55);
    wait_count("blk_drain", 0, 20);
    done = 1'b0;

    // Simultaneous pop of index 2, dispatch and CDB hit on shifting and dispatched entries
    do_reset();
    disp(1'b1, 16'h0, 6'd0, 32'h400, 1'b1, 6'd20, 32'h0, 1'b0);
    disp(1'b0, 16'h0, 6'd21, 32'h0, 1'b0, 6'd25, 32'h0, 1'b1);
    disp(1'b0, 16'h0, 6'd0, 32'h500, 1'b1, 6'd26, 32'h0, 1'b1);
    disp(1'b0, 16'h8, 6'd22, 32'h0, 1'b0, 6'd23, 32'h0, 1'b1);
    chk("full_state", {b_cnt, b_dr, b_rdy, b_addr}, {3'd4, 1'b0, 1'b1, 32'h500});
    expect_issue(1'b0, 6'd26, 32'h500, 32'h0);
    expect_issue(1'b0, 6'd23, 32'h608, 32'h0);
    expect_issue(1'b0, 6'd24, 32'h60C, 32'h0);
    expect_issue(1'b0, 6'd25, 32'h700, 32'h0);
    expect_issue(1'b1, 6'd20, 32'h400, 32'h77);
    done = 1'b1;
    #1;
    chk("full_pop_dready", b_dr, 1);
    d_op = 1'b0; d_off = 16'hC; d_rstag = 6'd22; d_rsv = 1'b0; d_rttag = 6'd24;
    d_rtdata = 32'h0; d_rtv = 1'b1; d_en = 1'b1;
    c_tag = 6'd22; c_data = 32'h600; c_valid = 1'b1;
    tick();
    d_en = 1'b0; c_valid = 1'b0;
    chk("simul_state", {b_cnt, b_rdy, b_addr}, {3'd4, 1'b1, 32'h608});
    wait_count("simul_drain2", 2, 20);
    cdb(6'd21, 32'h700);
    wait_count("simul_drain1", 1, 20);
    cdb(6'd20, 32'h77);
    wait_count("simul_drain0", 0, 20);
    done = 1'b0;

    // Store over store: the younger ready store must wait
    do_reset();
    disp(1'b1, 16'h0, 6'd0, 32'h800, 1'b1, 6'd30, 32'h0, 1'b0);
    disp(1'b1, 16'h0, 6'd0, 32'h900, 1'b1, 6'd31, 32'h99, 1'b1);
    done = 1'b1;
    tick(); tick();
    chk("sos_hold", {b_cnt, b_rdy}, {3'd2, 1'b0});
    expect_issue(1'b1, 6'd30, 32'h800, 32'h33);
    expect_issue(1'b1, 6'd31, 32'h900, 32'h99);
    cdb(6'd30, 32'h33);
    wait_count("sos_drain", 0, 20);
    done = 1'b0;

    tick();
    chk("leftover", expq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
